// File: rtl/instr_prefetch.sv
// instr_prefetch: credit-limited in-order instruction fetch into a DEPTH-entry {pc, instr} buffer with redirect flush
module instr_prefetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DW = (AW+2)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [63:0] fpc, rpc;
  logic [AW:0] count, outst, discard, outst_nx, discard_nx;
  logic [AW-1:0] rptr, wptr;
  logic [63:0] pc_mem [DEPTH];
  logic [31:0] ins_mem [DEPTH];
  logic gnt, rv, push, pop;
  assign imem_req_o = reset && state == RUN && !redirect_i && ({1'b0, count} + {1'b0, outst}) < DW;
  assign imem_addr_o = fpc;
  assign gnt = imem_req_o && imem_gnt_i;
  assign rv = imem_rvalid_i && outst != '0;
  assign push = rv && state == RUN && !redirect_i;
  assign pop = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_valid_o = count != '0;
  assign instr_o = instr_valid_o ? ins_mem[rptr] : '0;
  assign instr_pc_o = instr_valid_o ? pc_mem[rptr] : '0;
  always_comb begin
    outst_nx = gnt && !rv ? outst + ONE : rv && !gnt ? outst - ONE : outst;
    discard_nx = redirect_i ? outst_nx : state == DRAIN && rv ? discard - ONE : discard;
    state_nx = redirect_i ? (outst_nx != '0 ? DRAIN : RUN) : discard_nx == '0 ? RUN : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      fpc <= RESET_PC & ~64'h3;
      rpc <= RESET_PC & ~64'h3;
      count <= '0;
      outst <= '0;
      discard <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      state <= state_nx;
      outst <= outst_nx;
      discard <= discard_nx;
      if (redirect_i) begin
        fpc <= redirect_pc_i & ~64'h3;
        rpc <= redirect_pc_i & ~64'h3;
        count <= '0;
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (gnt) fpc <= fpc + 64'd4;
        if (push) rpc <= rpc + 64'd4;
        if (push) wptr <= wptr + AW'(1);
        if (pop) rptr <= rptr + AW'(1);
        count <= push && !pop ? count + ONE : pop && !push ? count - ONE : count;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr] <= rpc;
      ins_mem[wptr] <= imem_rdata_i;
    end
  end
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: randomized and directed checks of instr_prefetch against a queue-based reference model
module tb_instr_prefetch;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic imem_req_o, imem_gnt_i, imem_rvalid_i, instr_valid_o, instr_ready_i, redirect_i;
  logic [63:0] imem_addr_o, instr_pc_o, redirect_pc_i;
  logic [31:0] imem_rdata_i, instr_o;
  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int ng = 0;
  bit rd_addr = 1'b1;
  logic [63:0] m_fpc = RESET_PC;
  logic [63:0] f_pc[$];
  logic [31:0] f_in[$];
  logic [63:0] p_pc[$];
  bit p_st[$];
  logic [63:0] mq_a[$];
  int mq_t[$];
  instr_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    m_fpc = RESET_PC & ~64'h3;
    f_pc.delete();
    f_in.delete();
    p_pc.delete();
    p_st.delete();
    mq_a.delete();
    mq_t.delete();
  endtask
  task automatic rst_pulse();
    reset = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    chk("rst_req", imem_req_o, 64'h0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    chk("rst_valid", instr_valid_o, 64'h0);
    chk("rst_instr", instr_o, 64'h0);
    chk("rst_pc", instr_pc_o, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask
  task automatic cyc(input int gp, input int rp, input int yp, input bit redir = 1'b0,
                     input logic [63:0] rpc = 64'h0, input bit perr = 1'b0);
    logic g, r, y, ev, er;
    logic [31:0] rd;
    logic [63:0] ra;
    bit stale;
    r = perr || (mq_a.size() > 0 && mq_t[0] < ncyc && $urandom_range(99) < rp);
    ra = mq_a.size() > 0 ? mq_a[0] : 64'h0;
    rd = rd_addr ? ra[31:0] : $urandom();
    g = $urandom_range(99) < gp;
    y = $urandom_range(99) < yp;
    imem_gnt_i = g;
    imem_rvalid_i = r;
    imem_rdata_i = rd;
    instr_ready_i = y;
    redirect_i = redir;
    redirect_pc_i = rpc;
    stale = 1'b0;
    foreach (p_st[i]) stale |= p_st[i];
    ev = f_pc.size() != 0;
    er = !redir && !stale && (f_pc.size() + p_pc.size() < DEPTH);
    #1;
    chk("req", imem_req_o, er);
    chk("addr", imem_addr_o, m_fpc);
    chk("valid", instr_valid_o, ev);
    chk("pc", instr_pc_o, ev ? f_pc[0] : 64'h0);
    chk("instr", instr_o, ev ? f_in[0] : 32'h0);
    ng += int'(er && g);
    @(posedge clk);
    if (r && mq_a.size() > 0) begin
      mq_a.pop_front();
      mq_t.pop_front();
    end
    if (er && g) begin
      mq_a.push_back(m_fpc);
      mq_t.push_back(ncyc);
    end
    if (ev && y && !redir) begin
      f_pc.pop_front();
      f_in.pop_front();
    end
    if (r && p_pc.size() > 0) begin
      if (!redir && !p_st[0]) begin
        f_pc.push_back(p_pc[0]);
        f_in.push_back(rd);
      end
      p_pc.pop_front();
      p_st.pop_front();
    end
    if (er && g) begin
      p_pc.push_back(m_fpc);
      p_st.push_back(1'b0);
      m_fpc = m_fpc + 64'd4;
    end
    if (redir) begin
      f_pc.delete();
      f_in.delete();
      foreach (p_st[i]) p_st[i] = 1'b1;
      m_fpc = rpc & ~64'h3;
    end
    ncyc++;
    @(negedge clk);
  endtask
  initial begin
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    #1;
    rst_pulse();
    cyc(0, 0, 100, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(100, 100, 100);
    rst_pulse();
    ng = 0;
    for (int i = 0; i < 10; i++) cyc(100, 100, 0);
    chk("grants_full", ng, 64'd4);
    chk("head_pc_full", instr_pc_o, 64'h0);
    for (int i = 0; i < 10; i++) cyc(100, 100, 100);
    ng = 0;
    for (int i = 0; i < 3; i++) cyc(0, 100, 100);
    chk("grants_held", ng, 64'd0);
    cyc(100, 100, 100);
    chk("grants_one", ng, 64'd1);
    for (int i = 0; i < 6; i++) cyc(0, 100, 100);
    cyc(100, 0, 100);
    cyc(100, 0, 100);
    cyc(0, 0, 100, 1'b1, 64'h100);
    for (int i = 0; i < 4; i++) cyc(0, 100, 100);
    for (int i = 0; i < 6; i++) cyc(100, 100, 100);
    cyc(100, 100, 100, 1'b1, 64'h203);
    for (int i = 0; i < 6; i++) cyc(100, 100, 100);
    cyc(100, 100, 100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 8; i++) cyc(100, 100, 0);
    rst_pulse();
    rd_addr = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      int k;
      k = $urandom_range(999);
      if (k < 4) rst_pulse();
      else if (k < 35) cyc(60 + (i / 400) * 10, 60, 70, 1'b1, {$urandom(), $urandom()});
      else if (k < 40) cyc(80, 80, 50, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
      else cyc(60 + (i / 400) * 10, $urandom_range(20, 100), $urandom_range(0, 100));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
